// File: rtl/riscv_lsu_port_if.sv
// rtl/riscv_lsu_port_if.sv - request/response/memory bundle for riscv_lsu_port
//
// Groups the core-side request and response handshakes with the data-memory
// port of the load/store unit.
//   req_*   : core -> LSU request (valid/ready, write, funct3 size, addr, data)
//   resp_*  : LSU -> core response (valid/ready, extended data, fault)
//   mem_*   : LSU <-> BRAM (aligned address, lane data, byte strobes, read data)
// Modports:
//   slave  : the LSU view
//   master : the core + memory environment view
interface riscv_lsu_port_if #(
  parameter int XLEN = 32
);
  logic              req_valid_in;
  logic              req_ready_out;
  logic              req_write_in;
  logic [2:0]        req_size_in;
  logic [31:0]       req_addr_in;
  logic [XLEN-1:0]   req_data_in;

  logic              resp_valid_out;
  logic              resp_ready_in;
  logic [XLEN-1:0]   resp_data_out;
  logic              resp_fault_out;

  logic [31:0]       mem_addr_out;
  logic [XLEN-1:0]   mem_data_out;
  logic [XLEN/8-1:0] mem_write_enable_out;
  logic [XLEN-1:0]   mem_data_in;

  modport slave (
    input  req_valid_in, req_write_in, req_size_in, req_addr_in, req_data_in,
    input  resp_ready_in, mem_data_in,
    output req_ready_out, resp_valid_out, resp_data_out, resp_fault_out,
    output mem_addr_out, mem_data_out, mem_write_enable_out
  );

  modport master (
    output req_valid_in, req_write_in, req_size_in, req_addr_in, req_data_in,
    output resp_ready_in, mem_data_in,
    input  req_ready_out, resp_valid_out, resp_data_out, resp_fault_out,
    input  mem_addr_out, mem_data_out, mem_write_enable_out
  );
endinterface

// File: rtl/riscv_lsu_port.sv
// rtl/riscv_lsu_port.sv - RISC-V load/store port to a synchronous BRAM
//
// Accepts one load or store per request handshake. Stores drive byte strobes
// and lane-shifted data in the accept cycle; loads wait READ_LATENCY cycles,
// then return the selected lane sign- or zero-extended. Misaligned accesses
// and illegal sizes never touch memory and answer with a fault response.
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   step_in  : global advance enable; low freezes all state
//   lsu      : riscv_lsu_port_if.slave (request, response and memory signals)
// Parameters:
//   XLEN         : 32 or 64
//   READ_LATENCY : 1..15 cycles from address to mem_data_in valid
module riscv_lsu_port #(
  parameter int XLEN         = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            step_in,
  riscv_lsu_port_if.slave lsu
);

  localparam int         NB       = XLEN / 8;
  localparam int         OFFW     = $clog2(NB);
  localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic [OFFW-1:0]  off_q, off_d;
  logic [XLEN-1:0]  rdata_q, rdata_d;
  logic             fault_q, fault_d;

  logic             req_ready;
  logic             accept;
  logic             req_fault;
  logic             store_go;
  logic [OFFW-1:0]  req_off;
  logic [31:0]      req_addr_aligned;
  logic [3:0]       size_mask;
  logic [NB-1:0]    strb_base;

  logic [XLEN-1:0]        lane;
  logic [XLEN-1:0]        lane_top;
  logic signed [XLEN-1:0] lane_top_s;
  logic [XLEN-1:0]        load_ext;
  logic [6:0]             ext_sh;

  assign req_off          = lsu.req_addr_in[OFFW-1:0];
  assign req_addr_aligned = {lsu.req_addr_in[31:OFFW], {OFFW{1'b0}}};
  assign size_mask        = (4'd1 << lsu.req_size_in[1:0]) - 4'd1;

  always_comb begin
    req_fault = 1'b0;
    if (lsu.req_size_in == 3'b111) begin
      req_fault = 1'b1;
    end
    if (XLEN == 32 && (lsu.req_size_in == 3'b011 || lsu.req_size_in == 3'b110)) begin
      req_fault = 1'b1;
    end
    if ((4'(req_off) & size_mask) != 4'd0) begin
      req_fault = 1'b1;
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign req_ready = rst_n_in && step_in && (state_q == ST_IDLE);
  assign accept    = lsu.req_valid_in && req_ready;
  assign store_go  = accept && lsu.req_write_in && !req_fault;

  // 1 << size_bytes wraps to zero for a full-width access, so the subtraction
  // still yields an all-ones mask.
  assign strb_base = (NB'(1) << (4'd1 << lsu.req_size_in[1:0])) - NB'(1);

  assign lsu.req_ready_out        = req_ready;
  assign lsu.mem_write_enable_out = store_go ? (strb_base << req_off) : '0;
  assign lsu.mem_data_out         = store_go ? (lsu.req_data_in << {req_off, 3'b000}) : '0;
  assign lsu.mem_addr_out         = (state_q == ST_IDLE) ? req_addr_aligned : addr_q;

  assign lsu.resp_valid_out = (state_q == ST_RESP);
  assign lsu.resp_data_out  = rdata_q;
  assign lsu.resp_fault_out = fault_q;

  // Lane extraction: move the addressed lane to bit 0, then push it to the top
  // and shift back down, logically or arithmetically, to extend it.
  always_comb begin
    lane       = lsu.mem_data_in >> {off_q, 3'b000};
    ext_sh     = 7'(XLEN) - (7'd8 << size_q[1:0]);
    lane_top   = lane << ext_sh;
    lane_top_s = lane_top;
    if (size_q[2]) begin
      load_ext = lane_top >> ext_sh;
    end else begin
      load_ext = lane_top_s >>> ext_sh;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    if (step_in) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_d = req_addr_aligned;
            size_d = lsu.req_size_in;
            off_d  = req_off;
            if (req_fault) begin
              state_d = ST_RESP;
              fault_d = 1'b1;
              rdata_d = '0;
            end else if (lsu.req_write_in) begin
              state_d = ST_RESP;
              fault_d = 1'b0;
              rdata_d = '0;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            rdata_d = load_ext;
            fault_d = 1'b0;
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (lsu.resp_ready_in) begin
            state_d = ST_IDLE;
            rdata_d = '0;
            fault_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      size_q  <= 3'd0;
      off_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu_port.sv
// tb/tb_riscv_lsu_port.sv - directed self-checking bench for riscv_lsu_port
module tb_riscv_lsu_port;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic step  = 1'b1;
  bit   sel   = 1'b0;   // 0: 32-bit DUT (latency 2), 1: 64-bit DUT (latency 1)

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_lsu_port_if #(.XLEN(32)) if32 ();
  riscv_lsu_port_if #(.XLEN(64)) if64 ();

  riscv_lsu_port #(.XLEN(32), .READ_LATENCY(2)) u_dut32 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .step_in  (step),
    .lsu      (if32)
  );

  riscv_lsu_port #(.XLEN(64), .READ_LATENCY(1)) u_dut64 (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .step_in  (step),
    .lsu      (if64)
  );

  logic [63:0] s_ready, s_rvalid, s_fault, s_rdata, s_wdata, s_strb, s_addr;
  assign s_ready  = {63'd0, sel ? if64.req_ready_out  : if32.req_ready_out};
  assign s_rvalid = {63'd0, sel ? if64.resp_valid_out : if32.resp_valid_out};
  assign s_fault  = {63'd0, sel ? if64.resp_fault_out : if32.resp_fault_out};
  assign s_rdata  = sel ? if64.resp_data_out : {32'd0, if32.resp_data_out};
  assign s_wdata  = sel ? if64.mem_data_out  : {32'd0, if32.mem_data_out};
  assign s_strb   = sel ? {56'd0, if64.mem_write_enable_out} : {60'd0, if32.mem_write_enable_out};
  assign s_addr   = {32'd0, sel ? if64.mem_addr_out : if32.mem_addr_out};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input bit wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] md);
    if (sel) begin
      if64.req_valid_in = v;
      if64.req_write_in = wr;
      if64.req_size_in  = sz;
      if64.req_addr_in  = a;
      if64.req_data_in  = wd;
      if64.mem_data_in  = md;
    end else begin
      if32.req_valid_in = v;
      if32.req_write_in = wr;
      if32.req_size_in  = sz;
      if32.req_addr_in  = a;
      if32.req_data_in  = wd[31:0];
      if32.mem_data_in  = md[31:0];
    end
  endtask

  task automatic set_rready(input bit r);
    if (sel) if64.resp_ready_in = r;
    else     if32.resp_ready_in = r;
  endtask

  // Starts at posedge+1 of an IDLE cycle and returns at posedge+1 of the
  // cycle after the response has been retired.
  task automatic xact(input bit dut64, input bit wr, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] md,
                      input logic [63:0] e_strb, input logic [63:0] e_wdata, input int e_cyc,
                      input logic [63:0] e_data, input bit e_fault, input string tag);
    int          c;
    bit          late;
    logic [63:0] e_addr;
    sel    = dut64;
    e_addr = dut64 ? {32'd0, addr[31:3], 3'b000} : {32'd0, addr[31:2], 2'b00};
    drive(1'b1, wr, sz, addr, wd, md);
    #3;
    check({tag, " ready"}, s_ready, 64'd1);
    check({tag, " strb"}, s_strb, e_strb);
    check({tag, " wdata"}, s_wdata, e_wdata);
    check({tag, " addr0"}, s_addr, e_addr);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 64'd0, md);
    #3;
    c    = 1;
    late = 1'b0;
    while (s_rvalid == 64'd0 && c < 20) begin
      if (s_strb != 64'd0) late = 1'b1;
      @(posedge clk); #4;
      c++;
    end
    if (s_strb != 64'd0) late = 1'b1;
    check({tag, " resp_cycle"}, 64'(c), 64'(e_cyc));
    check({tag, " data"}, s_rdata, e_data);
    check({tag, " fault"}, s_fault, {63'd0, e_fault});
    check({tag, " late_strb"}, {63'd0, late}, 64'd0);
    check({tag, " addr_hold"}, s_addr, e_addr);
    set_rready(1'b1);
    @(posedge clk); #1;
    set_rready(1'b0);
    #3;
    check({tag, " retired"}, s_rvalid, 64'd0);
    check({tag, " ready_after"}, s_ready, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int bad;
    bit seen;

    sel = 1'b1; drive(1'b0, 1'b0, 3'b000, 32'd0, 64'd0, 64'd0); set_rready(1'b0);
    sel = 1'b0; drive(1'b0, 1'b0, 3'b000, 32'd0, 64'd0, 64'd0); set_rready(1'b0);

    // Reset held with a store request pending: nothing may be accepted.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 3'b000, 32'h1003, 64'hA5, 64'd0);
    repeat (2) @(posedge clk);
    #4;
    check("rst ready32", s_ready, 64'd0);
    check("rst ready64", {63'd0, if64.req_ready_out}, 64'd0);
    check("rst strb", s_strb, 64'd0);
    check("rst wdata", s_wdata, 64'd0);
    check("rst rvalid", s_rvalid, 64'd0);
    check("rst rdata", s_rdata, 64'd0);
    check("rst fault", s_fault, 64'd0);
    drive(1'b0, 1'b0, 3'b000, 32'd0, 64'd0, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #3;
    check("rel ready", s_ready, 64'd1);
    @(posedge clk); #1;

    // 32-bit, READ_LATENCY=2: stores respond in cycle 1, loads in cycle 3.
    xact(0, 1, 3'b000, 32'h1003, 64'hA5,       64'd0, 64'h08, 64'hA500_0000, 1, 64'd0, 0, "sb32");
    xact(0, 1, 3'b001, 32'h1002, 64'h1234ABCD, 64'd0, 64'h0C, 64'hABCD_0000, 1, 64'd0, 0, "sh32");
    xact(0, 1, 3'b010, 32'h1004, 64'hDEADBEEF, 64'd0, 64'h0F, 64'hDEAD_BEEF, 1, 64'd0, 0, "sw32");
    xact(0, 0, 3'b000, 32'h1002, 64'd0, 64'h00F0_0000, 64'd0, 64'd0, 3, 64'hFFFF_FFF0, 0, "lb32");
    xact(0, 0, 3'b100, 32'h1002, 64'd0, 64'h00F0_0000, 64'd0, 64'd0, 3, 64'h0000_00F0, 0, "lbu32");
    xact(0, 0, 3'b000, 32'h1001, 64'd0, 64'h0000_7F00, 64'd0, 64'd0, 3, 64'h0000_007F, 0, "lbpos32");
    xact(0, 0, 3'b001, 32'h1002, 64'd0, 64'h8001_0000, 64'd0, 64'd0, 3, 64'hFFFF_8001, 0, "lh32");
    xact(0, 0, 3'b101, 32'h1002, 64'd0, 64'h8001_0000, 64'd0, 64'd0, 3, 64'h0000_8001, 0, "lhu32");
    xact(0, 0, 3'b010, 32'h1000, 64'd0, 64'h1234_5678, 64'd0, 64'd0, 3, 64'h1234_5678, 0, "lw32");
    // Faults: never strobe, respond in cycle 1 with data 0.
    xact(0, 1, 3'b001, 32'h1001, 64'hFFFF, 64'hFFFF_FFFF, 64'd0, 64'd0, 1, 64'd0, 1, "sh_mis32");
    xact(0, 0, 3'b010, 32'h1002, 64'd0,    64'hFFFF_FFFF, 64'd0, 64'd0, 1, 64'd0, 1, "lw_mis32");
    xact(0, 0, 3'b011, 32'h1000, 64'd0,    64'hFFFF_FFFF, 64'd0, 64'd0, 1, 64'd0, 1, "ld32");
    xact(0, 0, 3'b110, 32'h1000, 64'd0,    64'hFFFF_FFFF, 64'd0, 64'd0, 1, 64'd0, 1, "lwu32");
    xact(0, 1, 3'b111, 32'h1000, 64'h1,    64'hFFFF_FFFF, 64'd0, 64'd0, 1, 64'd0, 1, "sz7_32");

    // 64-bit, READ_LATENCY=1: loads respond in cycle 2.
    xact(1, 0, 3'b110, 32'h2004, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 2, 64'h0000_0000_8000_0000, 0, "lwu64");
    xact(1, 0, 3'b010, 32'h2004, 64'd0, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 2, 64'hFFFF_FFFF_8000_0000, 0, "lw64");
    xact(1, 0, 3'b011, 32'h2000, 64'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, 2, 64'h0123_4567_89AB_CDEF, 0, "ld64");
    xact(1, 0, 3'b001, 32'h2006, 64'd0, 64'h8001_0000_0000_0000, 64'd0, 64'd0, 2, 64'hFFFF_FFFF_FFFF_8001, 0, "lh64");
    xact(1, 0, 3'b101, 32'h2006, 64'd0, 64'h8001_0000_0000_0000, 64'd0, 64'd0, 2, 64'h0000_0000_0000_8001, 0, "lhu64");
    xact(1, 1, 3'b011, 32'h2008, 64'h1122_3344_5566_7788, 64'd0, 64'hFF, 64'h1122_3344_5566_7788, 1, 64'd0, 0, "sd64");
    xact(1, 1, 3'b000, 32'h2005, 64'h7E, 64'd0, 64'h20, 64'h0000_7E00_0000_0000, 1, 64'd0, 0, "sb64");
    xact(1, 1, 3'b010, 32'h2004, 64'hCAFE_BABE, 64'd0, 64'hF0, 64'hCAFE_BABE_0000_0000, 1, 64'd0, 0, "sw64");
    xact(1, 0, 3'b010, 32'h2002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1, 64'd0, 1, "lw_mis64");
    xact(1, 0, 3'b011, 32'h2004, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1, 64'd0, 1, "ld_mis64");
    xact(1, 0, 3'b111, 32'h2000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1, 64'd0, 1, "sz7_64");

    // Backpressure then stall on the 32-bit DUT with a competing request.
    sel = 1'b0;
    drive(1'b1, 1'b0, 3'b010, 32'h1000, 64'd0, 64'hCAFE_F00D);
    #3;
    check("bp ready0", s_ready, 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 64'd0, 64'hCAFE_F00D);
    #3;
    c = 1;
    while (s_rvalid == 64'd0 && c < 20) begin
      @(posedge clk); #4;
      c++;
    end
    check("bp resp_cycle", 64'(c), 64'd3);
    bad = 0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 3'b000, 32'h1000, 64'h55, 64'hCAFE_F00D);
      step = (k >= 5 && k < 8) ? 1'b0 : 1'b1;
      set_rready(k >= 5);
      #3;
      if (s_rvalid != 64'd1 || s_rdata != 64'hCAFE_F00D || s_fault != 64'd0) bad++;
      if (s_ready != 64'd0 || s_strb != 64'd0 || s_wdata != 64'd0) bad++;
      if (!step && if64.req_ready_out) bad++;
    end
    check("bp held", 64'(bad), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 64'd0, 64'd0);
    set_rready(1'b0);
    #3;
    check("bp retired", s_rvalid, 64'd0);
    check("bp ready_after", s_ready, 64'd1);
    check("bp not_accepted", s_strb, 64'd0);
    @(posedge clk); #1;

    // Reset pulsed while a load is in WAIT.
    drive(1'b1, 1'b0, 3'b010, 32'h1000, 64'd0, 64'h1111_1111);
    #3;
    check("rw ready0", s_ready, 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'd0, 64'd0, 64'h1111_1111);
    rst_n = 1'b0;
    #3;
    check("rw ready_in_rst", s_ready, 64'd0);
    check("rw rvalid_in_rst", s_rvalid, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #3;
    check("rw ready_release", s_ready, 64'd1);
    seen = (s_rvalid != 64'd0);
    repeat (6) begin
      @(posedge clk); #4;
      if (s_rvalid != 64'd0) seen = 1'b1;
    end
    check("rw no_resp", {63'd0, seen}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
